// File: rtl/moore_seq_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Builds the KMP failure table and the full (state, bit) transition table as constants.
package moore_seq_pkg;

    localparam int MAX_LEN = 16;
    localparam int FW      = 5;                  // field width wide enough for 0..MAX_LEN

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    typedef logic [(MAX_LEN+1)*FW-1:0]   fail_tab_t;
    typedef logic [(MAX_LEN+1)*2*FW-1:0] delta_tab_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Entry k = longest proper prefix of the first k pattern bits that is also their suffix.
    function automatic fail_tab_t kmp_fail(input logic [MAX_LEN-1:0] pat, input int len);
        int        f [0:MAX_LEN];
        int        k;
        fail_tab_t t;
        for (int i = 0; i <= MAX_LEN; i++) f[i] = 0;
        k = 0;
        for (int i = 1; i < len; i++) begin
            while (k > 0 && pat[len-1-i] != pat[len-1-k]) k = f[k];
            if (pat[len-1-i] == pat[len-1-k]) k++;
            f[i+1] = k;
        end
        t = '0;
        for (int i = 0; i <= MAX_LEN; i++) t[i*FW +: FW] = FW'(f[i]);
        return t;
    endfunction

    // Entry (k*2+b) = next state from Sk on bit b; rows filled in increasing k so
    // fallback rows (always < k) are already final when referenced.
    function automatic delta_tab_t kmp_delta(input logic [MAX_LEN-1:0] pat, input int len,
                                             input bit ovl);
        fail_tab_t  f;
        delta_tab_t d;
        int         nxt;
        int         src;
        logic       bv;
        f = kmp_fail(pat, len);
        d = '0;
        for (int k = 0; k < len; k++) begin
            for (int b = 0; b < 2; b++) begin
                bv = b[0];
                if (pat[len-1-k] == bv)
                    nxt = k + 1;
                else if (k == 0)
                    nxt = 0;
                else
                    nxt = int'(d[(int'(f[k*FW +: FW])*2 + b)*FW +: FW]);
                d[(k*2+b)*FW +: FW] = FW'(nxt);
            end
        end
        src = ovl ? int'(f[len*FW +: FW]) : 0;
        for (int b = 0; b < 2; b++)
            d[(len*2+b)*FW +: FW] = d[(src*2+b)*FW +: FW];
        return d;
    endfunction

endpackage

// File: rtl/moore_seq_next_state.sv
// Combinational next-state lookup for the pattern detector (pure table mux, zero latency).
// No flow control: evaluated every cycle, the caller decides whether to load it.
module moore_seq_next_state
    import moore_seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic [clog2(PAT_LEN+1)-1:0] i_state,
    input  logic                        i_bit,
    output logic [clog2(PAT_LEN+1)-1:0] o_next_state
);

    localparam int         ST_W  = clog2(PAT_LEN + 1);
    localparam delta_tab_t DELTA = kmp_delta(MAX_LEN'(PATTERN), PAT_LEN, OVERLAP);

    int w_idx;

    // Encodings above PAT_LEN are unreachable and recover to S0.
    always_comb begin
        w_idx        = 0;
        o_next_state = '0;
        if (int'(i_state) <= PAT_LEN) begin
            w_idx        = (int'(i_state) * 2 + int'(i_bit)) * FW;
            o_next_state = DELTA[w_idx +: ST_W];
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector; Z decodes the registered state one cycle after the final bit.
// en=0 freezes everything; MOORE_SEQ_MATCH_CNT_EN adds a saturating match counter.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        I,
    output logic                        Z,
    output logic [clog2(PAT_LEN+1)-1:0] state,
    output logic [CNT_W-1:0]            match_count
);

    localparam int ST_W = clog2(PAT_LEN + 1);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next_state;

    moore_seq_next_state #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_next_state (
        .i_state      (r_state),
        .i_bit        (I),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= '0;
        else if (en)
            r_state <= w_next_state;
    end

    assign state = r_state;
    assign Z     = (r_state == ST_W'(PAT_LEN));

`ifdef MOORE_SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] r_match_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_match_count <= '0;
        else if (en && w_next_state == ST_W'(PAT_LEN) && r_match_count != '1)
            r_match_count <= r_match_count + 1'b1;
    end

    assign match_count = r_match_count;
`else
    assign match_count = '0;
`endif

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore-machine serial pattern detector. It is the generalised successor of the fixed 2-bit-state Moore lab machine.
- Samples a 1-bit serial input `I` each enabled clock edge and tracks the matched prefix of a compile-time pattern of arbitrary length.
- Asserts Moore output `Z` while in the full-match state.
- Exposes the state register for observation, as the lab machines do with their state bits.
- Adds selectable overlap/non-overlap detection and a sample enable.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern value, PAT_LEN bits wide; MSB is received first.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = detection restarts from empty after a match.
- CNT_W, 8, width of the match counter (optional feature only).
- ST_W, $clog2(PAT_LEN+1), derived state width; not overridable.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; `I` is consumed only when high.
- I  input  1  serial data bit.
- Z  output  1  Moore detect output; high iff state == PAT_LEN.
- state  output  ST_W  current state = number of pattern bits currently matched.
- match_count  output  CNT_W  saturating count of completed matches (optional feature).

Behaviour:
- Reset:
  - reset low asynchronously forces state=0, Z=0, match_count=0, regardless of clock or en.
  - Release is sampled on the first rising edge with reset high.
  - Reset mid-pattern discards partial progress; there is no pending match.
- States: S0..S_PAT_LEN, where Sk means the last k accepted bits equal the top k bits of PATTERN.
- Transition when en=1 and the machine is in Sk (k<PAT_LEN) with input bit b:
  - If b == PATTERN[PAT_LEN-1-k], go to S(k+1).
  - Otherwise go to Sj, where j is the longest proper prefix of PATTERN that is a suffix of (matched k bits followed by b). This is the KMP fallback; it may be 0.
  - The fallback table is computed at elaboration by a constant function. No runtime search.
- Transition from S_PAT_LEN:
  - OVERLAP=1: apply the same rule, treating the matched bits as the failure-prefix of the full pattern.
  - OVERLAP=0: apply the S0 transition to b. Result is S1 if b == PATTERN MSB, else S0.
- en=0: state holds; I is ignored; Z holds its value; no counting.
- Latency: Z goes high in the cycle immediately after the edge that accepts the final pattern bit, and stays high exactly while state == PAT_LEN.
  - For a period-1 pattern (e.g. all ones) with OVERLAP=1, consecutive matching bits keep Z high continuously.
- Z is a registered-state decode only. No combinational path from I or en to Z (pure Moore).
- Unreachable state encodings (> PAT_LEN) go to S0 on the next enabled edge.

Optional Feature:
- Macro: MOORE_SEQ_MATCH_CNT_EN.
- Defined:
  - match_count increments by 1 on every enabled edge whose next state is S_PAT_LEN.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Undefined: match_count is tied to 0 and no counter flops are inferred. The port remains for a stable interface.

Decomposition:
- Shared package moore_seq_pkg holds:
  - the constant function computing the KMP failure table from (PATTERN, PAT_LEN);
  - the clog2 helper;
  - default localparams (DEF_PAT_LEN=4, DEF_PATTERN=4'b1011).
- One natural sub-module: moore_seq_next_state. It is combinational, takes (state, I, OVERLAP, PATTERN) and returns next_state, and can be unit-tested standalone.
- Flops, Z decode and counter live in the top module.

Test Plan:
- Reset: drive 1,0,1 (state=3), then pulse reset low between edges → state=0, Z=0 immediately, before any clock edge; the next 1,0,1,1 yields Z=1 after the 4th edge.
- Basic: PATTERN=1011, OVERLAP=1, I=1,0,1,1 → state 1,2,3,4; Z=1 for exactly one cycle after the 4th edge, then the next bit 0 gives state=2, Z=0.
- Fallback: I=1,0,1,0,1,1 → states 1,2,3,2,3,4; single Z pulse after the 6th edge.
- Overlap mode: I=1,0,1,1,0,1,1 → OVERLAP=1 gives two Z pulses (after edges 4 and 7); OVERLAP=0 gives one pulse (after edge 4) and final state=1.
- Enable: I=1,0 with en=1, then 3 cycles of en=0 with I toggling, then en=1 with I=1,1 → state frozen at 2 during en=0; Z pulses after the final edge.
- Counter: MOORE_SEQ_MATCH_CNT_EN defined, CNT_W=2, five non-overlapping 1011 patterns → match_count 1,2,3,3,3; without the macro, match_count=0 throughout.
